// File: rtl/cubic_result_fifo_pkg.sv
// rtl/cubic_result_fifo_pkg.sv - shared types for the cubic result FIFO
//
// Purpose: stream beat types and the stored entry layout used by the FIFO,
// its memory and its interface.
//   TDATA_W                     : width of a result word (raw IEEE-754 bits)
//   fifo_entry_t                : one stored beat {tlast, tdata}
//   axi_stream_mastero_slavei_t : forward half of a stream (tvalid/tdata/tlast)
//   axi_stream_masteri_slaveo_t : backward half of a stream (tready)
package cubic_result_fifo_pkg;

  localparam int TDATA_W = 64;

  typedef struct packed {
    logic               tlast;
    logic [TDATA_W-1:0] tdata;
  } fifo_entry_t;

  typedef struct packed {
    logic               tvalid;
    logic [TDATA_W-1:0] tdata;
    logic               tlast;
  } axi_stream_mastero_slavei_t;

  typedef struct packed {
    logic tready;
  } axi_stream_masteri_slaveo_t;

endpackage

// File: rtl/cubic_result_fifo_if.sv
// rtl/cubic_result_fifo_if.sv - one stream link (forward beat + backward ready)
//
// Purpose: bundles both directions of a single stream hop.
//   m2s : beat travelling from producer to consumer
//   s2m : ready travelling from consumer to producer
// Modports:
//   master : producer side (drives m2s, samples s2m)
//   slave  : consumer side (samples m2s, drives s2m)
interface cubic_result_fifo_if;
  import cubic_result_fifo_pkg::*;

  axi_stream_mastero_slavei_t m2s;
  axi_stream_masteri_slaveo_t s2m;

  modport master (output m2s, input s2m);
  modport slave  (input m2s, output s2m);
endinterface

// File: rtl/cubic_result_fifo_mem.sv
// rtl/cubic_result_fifo_mem.sv - DEPTH x 65 storage, sync write, async read
//
// Purpose: entry array for the FIFO; contents are not reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : entry to store
//   raddr_i : read address
//   rdata_o : entry at raddr_i (combinational)
module cubic_result_fifo_mem
  import cubic_result_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fifo_entry_t   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fifo_entry_t   rdata_o
);

  fifo_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cubic_result_fifo.sv
// rtl/cubic_result_fifo.sv - first-word fall-through result FIFO with frame count
//
// Purpose: buffers 64-bit results from the cubic pipeline, preserving order
// and tlast framing, and counts completed output frames.
//   clk        : clock
//   rst        : synchronous active-high reset
//   prev_if    : upstream link (slave), beats in, tready out
//   next_if    : downstream link (master), beats out, tready in
//   count      : occupancy 0..DEPTH
//   frames_out : output handshakes carrying tlast, wraps
module cubic_result_fifo
  import cubic_result_fifo_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FRAME_W = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  cubic_result_fifo_if.slave  prev_if,
  cubic_result_fifo_if.master next_if,
  output logic [AW:0]         count,
  output logic [FRAME_W-1:0]  frames_out
);

  axi_stream_mastero_slavei_t previ;
  axi_stream_mastero_slavei_t nexto;
  axi_stream_masteri_slaveo_t prevo;
  axi_stream_masteri_slaveo_t nexti;

  assign previ        = prev_if.m2s;
  assign nexti        = next_if.s2m;
  assign prev_if.s2m  = prevo;
  assign next_if.m2s  = nexto;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [FRAME_W-1:0] frames_q, frames_d;

  logic        empty, full, push, pop;
  fifo_entry_t wr_entry, rd_entry;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
            (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Ready depends only on registered pointers: no path from downstream ready.
    prevo        = '0;
    prevo.tready = !full && !rst;

    // Fall-through output; forced to zero when nothing is buffered.
    nexto = '0;
    if (!empty && !rst) begin
      nexto.tvalid = 1'b1;
      nexto.tdata  = rd_entry.tdata;
      nexto.tlast  = rd_entry.tlast;
    end

    push = previ.tvalid && prevo.tready;
    pop  = nexto.tvalid && nexti.tready;

    wr_entry.tlast = previ.tlast;
    wr_entry.tdata = previ.tdata;

    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    frames_d = (pop && rd_entry.tlast) ? frames_q + FRAME_W'(1) : frames_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      frames_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      frames_q <= frames_d;
    end
  end

  assign count      = wr_ptr_q - rd_ptr_q;
  assign frames_out = frames_q;

  cubic_result_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_entry)
  );

  // Protocol checks. The previous cycle's stall state is remembered so that
  // a stalled beat can be compared against what is presented now; checking
  // is disarmed for the first edge after reset.
  logic               chk_armed_q;
  logic               chk_stall_q;
  logic [TDATA_W-1:0] chk_tdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_armed_q <= 1'b0;
      chk_stall_q <= 1'b0;
      chk_tdata_q <= '0;
    end else begin
      assert (!(previ.tlast && !previ.tvalid))
        else $error("cubic_result_fifo: upstream tlast high without tvalid");
      if (chk_armed_q && chk_stall_q) begin
        assert (nexto.tvalid)
          else $error("cubic_result_fifo: tvalid dropped without a pop");
        assert (nexto.tdata == chk_tdata_q)
          else $error("cubic_result_fifo: tdata changed while stalled");
      end
      chk_armed_q <= 1'b1;
      chk_stall_q <= nexto.tvalid && !nexti.tready;
      chk_tdata_q <= nexto.tdata;
    end
  end

endmodule

// File: tb/tb_cubic_result_fifo.sv
// tb/tb_cubic_result_fifo.sv - directed self-checking bench for cubic_result_fifo
module tb_cubic_result_fifo;
  import cubic_result_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  count;
  logic [15:0] frames_out;

  always #5 clk = ~clk;

  cubic_result_fifo_if prev_if ();
  cubic_result_fifo_if next_if ();

  cubic_result_fifo #(
    .DEPTH   (8),
    .FRAME_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prev_if    (prev_if),
    .next_if    (next_if),
    .count      (count),
    .frames_out (frames_out)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic l);
    prev_if.m2s.tvalid = v;
    prev_if.m2s.tdata  = d;
    prev_if.m2s.tlast  = l;
  endtask

  logic [63:0] exp_d [20];
  int          sent;
  int          recv;
  logic        do_push;

  initial begin
    rst = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    next_if.s2m.tready = 1'b0;

    // Reset held for three cycles.
    repeat (3) begin
      tick();
      chk("rst_count",  64'(count), 64'd0);
      chk("rst_tvalid", 64'(next_if.m2s.tvalid), 64'd0);
      chk("rst_tready", 64'(prev_if.s2m.tready), 64'd0);
    end
    chk("rst_tdata",  next_if.m2s.tdata, 64'd0);
    chk("rst_frames", 64'(frames_out), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_tready", 64'(prev_if.s2m.tready), 64'd1);

    // Fill to full with consumer stalled.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, $realtobits(real'(i + 1)), i == 7);
      tick();
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("fill_head",  next_if.m2s.tdata, $realtobits(1.0));
    end
    drive(1'b0, 64'd0, 1'b0);
    #1;
    chk("full_tready", 64'(prev_if.s2m.tready), 64'd0);
    chk("full_tvalid", 64'(next_if.m2s.tvalid), 64'd1);

    // A push attempt while full is ignored.
    drive(1'b1, $realtobits(99.0), 1'b0);
    tick();
    drive(1'b0, 64'd0, 1'b0);
    chk("full_push_count", 64'(count), 64'd8);
    chk("full_push_head",  next_if.m2s.tdata, $realtobits(1.0));

    // Drain in order on consecutive cycles.
    next_if.s2m.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_tvalid", 64'(next_if.m2s.tvalid), 64'd1);
      chk("drain_tdata",  next_if.m2s.tdata, $realtobits(real'(i + 1)));
      chk("drain_tlast",  64'(next_if.m2s.tlast), 64'(i == 7));
      tick();
      chk("drain_count", 64'(count), 64'(7 - i));
    end
    chk("drain_frames", 64'(frames_out), 64'd1);
    chk("drain_tvalid_end", 64'(next_if.m2s.tvalid), 64'd0);
    chk("drain_tdata_end",  next_if.m2s.tdata, 64'd0);
    chk("drain_tlast_end",  64'(next_if.m2s.tlast), 64'd0);

    // Simultaneous push and pop at count 3.
    next_if.s2m.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $realtobits(real'(10 + i)), 1'b0);
      tick();
    end
    chk("sim_pre_count", 64'(count), 64'd3);
    drive(1'b1, $realtobits(9.5), 1'b0);
    next_if.s2m.tready = 1'b1;
    #1;
    chk("sim_head", next_if.m2s.tdata, $realtobits(10.0));
    tick();
    drive(1'b0, 64'd0, 1'b0);
    chk("sim_count", 64'(count), 64'd3);
    chk("sim_order0", next_if.m2s.tdata, $realtobits(11.0));
    tick();
    chk("sim_order1", next_if.m2s.tdata, $realtobits(12.0));
    tick();
    chk("sim_order2", next_if.m2s.tdata, $realtobits(9.5));
    tick();
    chk("sim_empty", 64'(count), 64'd0);
    chk("sim_frames", 64'(frames_out), 64'd1);

    // Stream 20 beats across pointer wrap with ready pattern 1,0,1,1.
    for (int i = 0; i < 20; i++) exp_d[i] = $realtobits(100.0 + real'(i));
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 200 && recv < 20; cyc++) begin
      next_if.s2m.tready = ((cyc % 4) != 1);
      if (sent < 20) drive(1'b1, exp_d[sent], (sent % 5) == 4);
      else           drive(1'b0, 64'd0, 1'b0);
      #1;
      do_push = prev_if.m2s.tvalid && prev_if.s2m.tready;
      if (next_if.m2s.tvalid && next_if.s2m.tready) begin
        chk("wrap_tdata", next_if.m2s.tdata, exp_d[recv]);
        chk("wrap_tlast", 64'(next_if.m2s.tlast), 64'((recv % 5) == 4));
        recv++;
      end
      if (do_push) sent++;
      tick();
    end
    drive(1'b0, 64'd0, 1'b0);
    chk("wrap_recv",   64'(recv), 64'd20);
    chk("wrap_count",  64'(count), 64'd0);
    chk("wrap_frames", 64'(frames_out), 64'd5);

    // Reset mid-stream with five beats buffered.
    next_if.s2m.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $realtobits(200.0 + real'(i)), i == 4);
      tick();
    end
    drive(1'b0, 64'd0, 1'b0);
    chk("mid_pre_count", 64'(count), 64'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_tready", 64'(prev_if.s2m.tready), 64'd0);
    tick();
    chk("mid_count",  64'(count), 64'd0);
    chk("mid_tvalid", 64'(next_if.m2s.tvalid), 64'd0);
    chk("mid_frames", 64'(frames_out), 64'd0);
    rst = 1'b0;
    next_if.s2m.tready = 1'b1;
    #1;
    chk("mid_tready", 64'(prev_if.s2m.tready), 64'd1);
    repeat (3) begin
      tick();
      chk("mid_no_emit", 64'(next_if.m2s.tvalid), 64'd0);
    end
    drive(1'b1, $realtobits(300.0), 1'b1);
    tick();
    drive(1'b0, 64'd0, 1'b0);
    chk("mid_new_tvalid", 64'(next_if.m2s.tvalid), 64'd1);
    chk("mid_new_tdata",  next_if.m2s.tdata, $realtobits(300.0));
    chk("mid_new_tlast",  64'(next_if.m2s.tlast), 64'd1);
    tick();
    chk("mid_new_frames", 64'(frames_out), 64'd1);
    chk("mid_new_count",  64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
